// File: rtl/bus_node_pkg.sv
// Shared widths, defaults and helpers for the bus node endpoint.
// Destination ID lives in the top ID_W bits of every package.
package bus_node_pkg;

    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BROADCAST = {ID_W{1'b1}};

    // Packages are passed zero-extended to 64 bits together with their real width.
    function automatic logic [ID_W-1:0] dest_of(input logic [63:0] pkg, input int unsigned sz);
        logic [63:0] shifted;
        shifted = pkg >> (sz - ID_W);
        return shifted[ID_W-1:0];
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers.
// A read and a write in the same cycle are both honoured, even when full.
module sync_fifo #(
    parameter int width = 16,
    parameter int depth = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [width-1:0] wdata,
    input  logic             rd,
    output logic [width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign rd_en = rd && !empty;
    // A read in the same cycle frees the slot the write lands in.
    assign wr_en = wr && (!full || rd_en);

    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define validity,
    // and leaving the array reset-free lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (reset && wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/bus_node_endpoint.sv
// Device-side bus endpoint: TX FIFO toward the arbiter, ID-filtered RX FIFO
// from it, plus drop/overflow counters and a sticky pop-underflow flag.
module bus_node_endpoint
    import bus_node_pkg::*;
#(
    parameter int                pckg_sz   = 16,
    parameter int                depth     = 8,
    parameter logic [ID_W-1:0]   id        = '0,
    parameter logic [ID_W-1:0]   broadcast = BROADCAST
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               tx_wr,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    input  logic               rx_rd,
    output logic [pckg_sz-1:0] rx_data,
    output logic               rx_empty,
    output logic [7:0]         drop_cnt,
    output logic [7:0]         ovf_cnt,
    output logic               pop_err
);

    logic            tx_empty;
    logic            rx_full;
    logic [ID_W-1:0] dest;
    logic            accept;

    assign dest   = dest_of(64'(D_push), pckg_sz);
    assign accept = (dest == id) || (dest == broadcast);
    assign pndng  = !tx_empty;

    sync_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (tx_wr),
        .wdata (tx_data),
        .rd    (pop),
        .rdata (D_pop),
        .full  (tx_full),
        .empty (tx_empty)
    );

    sync_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (push && accept),
        .wdata (D_push),
        .rd    (rx_rd),
        .rdata (rx_data),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // simply takes priority over any same-edge push/pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt <= '0;
            ovf_cnt  <= '0;
            pop_err  <= 1'b0;
        end else begin
            if (push && !accept) drop_cnt <= sat_inc8(drop_cnt);
            // A full RX is never empty, so a same-cycle rx_rd always frees a slot.
            if (push && accept && rx_full && !rx_rd) ovf_cnt <= sat_inc8(ovf_cnt);
            if (pop && tx_empty) pop_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_node_endpoint.sv
// Directed bench for bus_node_endpoint (id=2, 16-bit packages, depth 8).
// A vector table covers the basic paths; hand sequences cover the corner cases.
module tb_bus_node_endpoint;

    logic        clk = 1'b0;
    logic        reset;
    logic        pndng;
    logic [15:0] D_pop;
    logic        pop;
    logic        push;
    logic [15:0] D_push;
    logic        tx_wr;
    logic [15:0] tx_data;
    logic        tx_full;
    logic        rx_rd;
    logic [15:0] rx_data;
    logic        rx_empty;
    logic [7:0]  drop_cnt;
    logic [7:0]  ovf_cnt;
    logic        pop_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        pndng;
        logic [15:0] d_pop;
        logic        tx_full;
        logic        rx_empty;
        logic [15:0] rx_data;
        logic [7:0]  drop;
        logic [7:0]  ovf;
        logic        pop_err;
    } exp_t;

    typedef struct {
        logic        tx_wr;
        logic [15:0] tx_data;
        logic        pop;
        logic        push;
        logic [15:0] d_push;
        logic        rx_rd;
        exp_t        exp;
    } vec_t;

    localparam exp_t RESET_EXP = '{1'b0, 16'h0, 1'b0, 1'b1, 16'h0, 8'd0, 8'd0, 1'b0};

    vec_t vecs [10];

    bus_node_endpoint #(
        .pckg_sz (16),
        .depth   (8),
        .id      (8'h02)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .tx_wr    (tx_wr),
        .tx_data  (tx_data),
        .tx_full  (tx_full),
        .rx_rd    (rx_rd),
        .rx_data  (rx_data),
        .rx_empty (rx_empty),
        .drop_cnt (drop_cnt),
        .ovf_cnt  (ovf_cnt),
        .pop_err  (pop_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, ".pndng"},    32'(pndng),    32'(e.pndng));
        check({tag, ".D_pop"},    32'(D_pop),    32'(e.d_pop));
        check({tag, ".tx_full"},  32'(tx_full),  32'(e.tx_full));
        check({tag, ".rx_empty"}, 32'(rx_empty), 32'(e.rx_empty));
        check({tag, ".rx_data"},  32'(rx_data),  32'(e.rx_data));
        check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(e.drop));
        check({tag, ".ovf_cnt"},  32'(ovf_cnt),  32'(e.ovf));
        check({tag, ".pop_err"},  32'(pop_err),  32'(e.pop_err));
    endtask

    // Drive one cycle of inputs, clock it in, sample #1 after the edge, then idle the inputs.
    task automatic cycle(input logic w, input logic [15:0] wd, input logic p,
                         input logic ps, input logic [15:0] pd, input logic r);
        tx_wr = w; tx_data = wd; pop = p; push = ps; D_push = pd; rx_rd = r;
        @(posedge clk);
        #1;
        tx_wr = 1'b0; tx_data = '0; pop = 1'b0; push = 1'b0; D_push = '0; rx_rd = 1'b0;
    endtask

    initial begin
        // tx_wr, tx_data, pop, push, d_push, rx_rd, {pndng, D_pop, tx_full, rx_empty, rx_data, drop, ovf, pop_err}
        vecs[0] = '{1'b1, 16'h05AA, 1'b0, 1'b0, 16'h0,    1'b0, '{1'b1, 16'h05AA, 1'b0, 1'b1, 16'h0,    8'd0, 8'd0, 1'b0}};
        vecs[1] = '{1'b1, 16'h0155, 1'b0, 1'b0, 16'h0,    1'b0, '{1'b1, 16'h05AA, 1'b0, 1'b1, 16'h0,    8'd0, 8'd0, 1'b0}};
        vecs[2] = '{1'b0, 16'h0,    1'b1, 1'b0, 16'h0,    1'b0, '{1'b1, 16'h0155, 1'b0, 1'b1, 16'h0,    8'd0, 8'd0, 1'b0}};
        vecs[3] = '{1'b0, 16'h0,    1'b1, 1'b0, 16'h0,    1'b0, '{1'b0, 16'h0,    1'b0, 1'b1, 16'h0,    8'd0, 8'd0, 1'b0}};
        vecs[4] = '{1'b0, 16'h0,    1'b0, 1'b1, 16'h02C3, 1'b0, '{1'b0, 16'h0,    1'b0, 1'b0, 16'h02C3, 8'd0, 8'd0, 1'b0}};
        vecs[5] = '{1'b0, 16'h0,    1'b0, 1'b1, 16'hFF11, 1'b0, '{1'b0, 16'h0,    1'b0, 1'b0, 16'h02C3, 8'd0, 8'd0, 1'b0}};
        vecs[6] = '{1'b0, 16'h0,    1'b0, 1'b1, 16'h0377, 1'b0, '{1'b0, 16'h0,    1'b0, 1'b0, 16'h02C3, 8'd1, 8'd0, 1'b0}};
        vecs[7] = '{1'b0, 16'h0,    1'b0, 1'b0, 16'h0,    1'b1, '{1'b0, 16'h0,    1'b0, 1'b0, 16'hFF11, 8'd1, 8'd0, 1'b0}};
        vecs[8] = '{1'b0, 16'h0,    1'b0, 1'b0, 16'h0,    1'b1, '{1'b0, 16'h0,    1'b0, 1'b1, 16'h0,    8'd1, 8'd0, 1'b0}};
        vecs[9] = '{1'b0, 16'h0,    1'b0, 1'b0, 16'h0,    1'b1, '{1'b0, 16'h0,    1'b0, 1'b1, 16'h0,    8'd1, 8'd0, 1'b0}};

        tx_wr = 1'b0; tx_data = '0; pop = 1'b0; push = 1'b0; D_push = '0; rx_rd = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", RESET_EXP);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].tx_wr, vecs[i].tx_data, vecs[i].pop, vecs[i].push, vecs[i].d_push, vecs[i].rx_rd);
            check_all($sformatf("vec%0d", i), vecs[i].exp);
        end

        // RX overflow: 8 fill, 9th lost
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b0, 1'b1, 16'h0200 + 16'(i), 1'b0);
        check("ovf_before", 32'(ovf_cnt), 32'd0);
        cycle(1'b0, '0, 1'b0, 1'b1, 16'h0299, 1'b0);
        check("ovf_after_9th", 32'(ovf_cnt), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rx_ovf_order%0d", i), 32'(rx_data), 32'h0200 + 32'(i));
            cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        end
        check("rx_empty_after_drain", 32'(rx_empty), 32'd1);

        // RX full with same-cycle read: push is stored, no overflow
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b0, 1'b1, 16'h0210 + 16'(i), 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 16'h0299, 1'b1);
        check("ovf_with_rd", 32'(ovf_cnt), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rx_rdfull_order%0d", i), 32'(rx_data), (i == 7) ? 32'h0299 : 32'h0211 + 32'(i));
            cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        end
        check("rx_empty_after_rdfull", 32'(rx_empty), 32'd1);

        // pop on empty TX sets sticky pop_err
        cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        check("pop_err_set", 32'(pop_err), 32'd1);
        check("pop_err_no_pndng", 32'(pndng), 32'd0);
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        check("pop_err_sticky", 32'(pop_err), 32'd1);

        // TX fill, ignored 9th write, write+pop while full
        for (int i = 0; i < 8; i++) cycle(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0, '0, 1'b0);
        check("tx_full_8", 32'(tx_full), 32'd1);
        cycle(1'b1, 16'h10FF, 1'b0, 1'b0, '0, 1'b0);
        check("tx_full_9th", 32'(tx_full), 32'd1);
        check("tx_head_9th", 32'(D_pop), 32'h1000);
        cycle(1'b1, 16'h1100, 1'b1, 1'b0, '0, 1'b0);
        check("tx_full_wr_pop", 32'(tx_full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tx_order%0d", i), 32'(D_pop), (i == 7) ? 32'h1100 : 32'h1001 + 32'(i));
            cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        end
        check("tx_empty_after_drain", 32'(pndng), 32'd0);
        check("tx_drain_d_pop_zero", 32'(D_pop), 32'd0);

        // write and pop on empty TX: write lands
        cycle(1'b1, 16'h0ABC, 1'b1, 1'b0, '0, 1'b0);
        check("wr_pop_empty_pndng", 32'(pndng), 32'd1);
        check("wr_pop_empty_data", 32'(D_pop), 32'h0ABC);
        cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        check("wr_pop_empty_drained", 32'(pndng), 32'd0);

        // drop counter saturation: starts at 1
        for (int i = 0; i < 253; i++) cycle(1'b0, '0, 1'b0, 1'b1, 16'h0700 + 16'(i), 1'b0);
        check("drop_254", 32'(drop_cnt), 32'd254);
        for (int i = 0; i < 47; i++) cycle(1'b0, '0, 1'b0, 1'b1, 16'h0700 + 16'(i), 1'b0);
        check("drop_sat", 32'(drop_cnt), 32'd255);
        check("drop_rx_untouched", 32'(rx_empty), 32'd1);

        // reset mid-operation with both FIFOs half full and same-edge traffic
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b1, 16'h0220 + 16'(i), 1'b0);
        check("half_pndng", 32'(pndng), 32'd1);
        check("half_rx_empty", 32'(rx_empty), 32'd0);
        reset = 1'b0;
        cycle(1'b1, 16'h2222, 1'b1, 1'b1, 16'h0233, 1'b1);
        check_all("mid_reset", RESET_EXP);
        reset = 1'b1;
        cycle(1'b1, 16'h0ABC, 1'b0, 1'b1, 16'h0255, 1'b0);
        check("post_reset_d_pop", 32'(D_pop), 32'h0ABC);
        check("post_reset_rx_data", 32'(rx_data), 32'h0255);
        cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
        check("post_reset_pndng", 32'(pndng), 32'd0);
        check("post_reset_rx_empty", 32'(rx_empty), 32'd1);
        check("post_reset_pop_err", 32'(pop_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_node_endpoint.md
# bus_node_endpoint

Synthesizable device-side endpoint for one port of the bus generator/arbiter (`bs_gnrtr_n_rbtr`). It buffers outgoing packages in a TX FIFO and offers them to the bus through the `pndng`/`pop`/`D_pop` handshake. It accepts packages delivered through `push`/`D_push` into an RX FIFO after filtering on destination ID. It replaces the behavioural driver/monitor on any port where real hardware attaches to the bus.

## Interface
Parameters:
- `pckg_sz`, 16: package width in bits; bits [pckg_sz-1 -: 8] are the destination ID.
- `depth`, 8: entries per FIFO; a power of two, ≥ 2.
- `id`, 0: this node's 8-bit ID.
- `broadcast`, {8{1'b1}}: destination value accepted by every node.

Ports:
- `clk` in 1: the only clock.
- `reset` in 1: reset is synchronous and active-low; asserted when `reset`=0 at a rising edge of `clk`.
- `pndng` out 1: TX FIFO not empty; drives the arbiter's `pndng` bit for this port.
- `D_pop` out pckg_sz: TX head, show-ahead.
- `pop` in 1: the bus consumes the TX head at this edge.
- `push` in 1: the bus delivers `D_push` at this edge.
- `D_push` in pckg_sz: delivered package.
- `tx_wr` in 1 / `tx_data` in pckg_sz: user enqueue.
- `tx_full` out 1: TX FIFO full.
- `rx_rd` in 1: user dequeue.
- `rx_data` out pckg_sz: RX head, show-ahead.
- `rx_empty` out 1: RX FIFO empty.
- `drop_cnt` out 8: count of filtered (misrouted) packages; saturates at 255.
- `ovf_cnt` out 8: count of accepted packages lost because RX was full; saturates at 255.
- `pop_err` out 1: sticky; set by `pop` while TX is empty.

## Operation
- TX path: `tx_wr` with `tx_full`=0 writes `tx_data` at the tail. `tx_wr` while full is ignored and the data is lost.
- `pop` with `pndng`=1 advances the TX head.
- `pop` with `pndng`=0 has no effect on FIFO state and sets `pop_err`. Only reset clears `pop_err`.
- `D_pop` equals the TX head while `pndng`=1, and 0 while empty.
- RX filter: a package is accepted when dest == `id` or dest == `broadcast`. Otherwise `drop_cnt` increments and nothing is stored.
- An accepted package is written to RX if not full. If RX is full it is lost and `ovf_cnt` increments.
- `rx_rd` with `rx_empty`=0 advances the RX head. `rx_rd` while empty is ignored.
- `rx_data` equals the RX head when non-empty, and 0 when empty.
- Simultaneous events:
  - TX write and pop in the same cycle with TX non-empty: both happen; occupancy is unchanged.
  - TX write and pop in the same cycle with TX empty: the write happens and `pop_err` is set.
  - RX push (accepted) and `rx_rd` in the same cycle with RX full: the read frees a slot, the push is stored, and no overflow is counted.
- FIFO pointers are log2(depth)+1 bits; the MSB is the wrap bit. Full when the pointers are equal except the MSB; empty when they are fully equal.
- Reset: both FIFOs are emptied, counters cleared, `pop_err` cleared. Stored contents are discarded.

## Timing
- Reset values: `pndng`=0, `D_pop`=0, `tx_full`=0, `rx_empty`=1, `rx_data`=0, `drop_cnt`=0, `ovf_cnt`=0, `pop_err`=0.
- Enqueue latency is 1: `tx_wr` at edge N gives `pndng`=1 and valid `D_pop` in the cycle after edge N.
- Delivery latency is 1: `push` at edge N gives `rx_empty`=0 and `rx_data` valid after edge N.
- The counters update at the same edge as the triggering `push`.
- `D_pop`/`rx_data` are combinational from storage and pointers. `pndng`, `tx_full`, `rx_empty` and the status outputs are derived from registers only; there is no input-to-output combinational path.
- Reset mid-operation: a `pop`, `push`, `tx_wr` or `rx_rd` at the same edge as reset is discarded. The next cycle shows the reset values.
- Counter saturation: at 255, a further event leaves the counter at 255.

## Structure
- Package `bus_node_pkg`:
  - `ID_W`=8.
  - Default `BROADCAST`.
  - Function `dest_of(pkg)` returning the top `ID_W` bits.
  - `sat_inc8` helper.
- Sub-module `sync_fifo` (show-ahead; parameters `width`, `depth`; ports `clk`, `reset`, `wr`, `wdata`, `rd`, `rdata`, `full`, `empty`) is instantiated twice, once for TX and once for RX.
- The top level holds the filter, the counters and `pop_err`.

## Test plan
All scenarios use `id`=2, `pckg_sz`=16, `depth`=8.
- Write `tx_data` 16'h05AA then 16'h0155; pulse `pop` twice → `D_pop` reads 05AA then 0155; `pndng` falls after the second pop; `pop_err`=0.
- Push 16'h02C3, then 16'hFF11, then 16'h0377 → RX holds C3 and 11 in order; `drop_cnt`=1; `rx_empty` clears one cycle after the first push.
- Fill RX with 8 packages for dest 02, then push a 9th → `ovf_cnt`=1 and RX holds the first 8. Repeat with `rx_rd` asserted in the same cycle → `ovf_cnt` stays 1 and the 9th package is stored.
- `pop` with TX empty → `pop_err`=1 and stays set. Then fill TX with 8 writes; a 9th write is ignored; `tx_full`=1. Simultaneous write and pop while full → `tx_full` stays 1 and order is preserved.
- Push 300 packages for dest 07 → `drop_cnt` saturates at 255.
- Assert reset (`reset`=0) while both FIFOs are half full, together with `push` and `pop` in the same cycle → the next cycle shows all reset values; the following write/read works from empty.
